ascon_block_sequencer: RTL
==========================

// Module: ascon_block_sequencer
// PURPOSE
//  Autonomous multi-block feeder between the CW305 register file and the Ascon-128a core. Host preloads up to
//  pAD_DEPTH associated-data blocks and pMSG_DEPTH message blocks, then pulses go. The block streams them
//  into the core with valid/last/eot/select handshakes and captures every ciphertext block into a buffer.
//  This replaces per-block host polling of REG_CRYPT_STATUS, which keeps USB traffic out of the trace window.
// PARAMETERS
//  pDATA_WIDTH  128   block width in bits (core rate)
//  pAD_DEPTH    4     AD buffer entries (>=1)
//  pMSG_DEPTH   4     message/ciphertext buffer entries (>=1)
//  pTIMEOUT     4096  max cycles waiting on any single core handshake before ERROR
// PORTS
//  clk            in   1    crypto clock (pll_clk1 domain)
//  rst_n          in   1    asynchronous active-low reset
//  wr_en          in   1    host buffer write strobe
//  wr_sel         in   1    0=AD buffer, 1=MSG buffer
//  wr_addr        in   clog2(max depth)  entry index
//  wr_data        in   pDATA_WIDTH  block data
//  ad_blocks      in   clog2(pAD_DEPTH+1)   AD blocks to send (0 allowed)
//  msg_blocks     in   clog2(pMSG_DEPTH+1)  MSG blocks to send (0 allowed)
//  ad_last_bytes  in   5    valid bytes of final AD block (1..16)
//  msg_last_bytes in   5    valid bytes of final MSG block (1..16)
//  go             in   1    start pulse
//  rd_addr        in   clog2(pMSG_DEPTH)  ciphertext buffer read index
//  rd_data        out  pDATA_WIDTH  ciphertext at rd_addr (1-cycle registered read)
//  core_data      out  pDATA_WIDTH  block to core
//  core_valid     out  1    block valid
//  core_last      out  1    final block of current type
//  core_eot       out  1    final message block (end of text)
//  core_select    out  1    0=AD, 1=MSG
//  core_bytes     out  5    valid bytes of presented block
//  core_read      in   1    core accepted block (1-cycle pulse)
//  core_ct_valid  in   1    core_ct valid (1-cycle pulse)
//  core_ct        in   pDATA_WIDTH  ciphertext block
//  core_done      in   1    tag ready / operation complete pulse
//  busy, done, error  out 1 each   status bits for REG_CRYPT_STATUS
//  ct_count       out  clog2(pMSG_DEPTH+1)  ciphertext blocks captured
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; all outputs 0; indices, ct_count, timeout counter cleared; buffer contents undefined.
//  - FSM: IDLE -> (go) SEND_AD if ad_blocks>0 else SEND_MSG -> WAIT_DONE -> DONE; any timeout -> ERROR.
//    DONE/ERROR -> IDLE on next go (which also starts a new run the same cycle). go ignored while busy.
//  - busy=1 in SEND_AD/SEND_MSG/WAIT_DONE; done=1 only in DONE; error=1 only in ERROR.
//  - go samples ad_blocks/msg_blocks/last_bytes into internal registers; later input changes have no effect.
//  - Handshake: core_valid rises 1 cycle after entering a SEND state, holds data/flags stable until core_read.
//    Cycle after core_read: core_valid=0; next block presented the cycle after that (1 idle cycle between blocks).
//  - core_last=1 on final block of each type; core_eot=1 only on final MSG block. core_bytes=16 except final block.
//  - msg_blocks=0: send one empty MSG block, core_bytes=0, last=eot=1 (padding-only block).
//  - Capture: on core_ct_valid, ct_buf[ct_count]<=core_ct, ct_count++. Captures allowed in SEND_MSG and WAIT_DONE.
//    ct_count reaching pMSG_DEPTH with another core_ct_valid -> ERROR, no wrap, no overwrite.
//  - WAIT_DONE entered after final MSG core_read; core_done -> DONE. core_done before that -> ERROR.
//  - Timeout: counter resets on every state change, core_read, or core_ct_valid; reaching pTIMEOUT -> ERROR.
//  - core_read while core_valid=0 ignored. Simultaneous core_read and core_ct_valid both honoured.
//  - wr_en while busy ignored (buffer write-protected during run). Out-of-range wr_addr ignored.
//  - rd_data valid any time; reading during a run returns whatever is already captured.
// TESTING
//  - Reset mid-SEND_MSG (rst_n low 2 cycles) -> outputs 0, busy=0, ct_count=0; fresh go runs normally.
//  - ad=1 (16B), msg=1 (16B) from KAT key/nonce -> AD presented select=0,last=1; MSG select=1,last=eot=1;
//    rd_data[0]=128'h8a278bf8fa2812bc39e52c76205af377, done=1, ct_count=1.
//  - ad=0, msg=0 -> SEND_AD skipped; single MSG block bytes=0,last=eot=1; done after core_done; ct_count=0.
//  - ad=4, msg=4, core_read delayed 0..7 random cycles -> data stable while valid; 1 gap cycle; ct order 0..3.
//  - Core never pulses core_read -> error=1 exactly pTIMEOUT cycles after core_valid rose; busy=0.
//  - 5 core_ct_valid pulses with pMSG_DEPTH=4 -> error=1, ct_buf[3] keeps 4th block; go while busy ignored.

Source files
------------

// File: rtl/ascon_core_if.sv
// Block handshake between the multi-block sequencer and the Ascon-128a core.
// master: sequencer side (drives blocks); slave: core side (accepts, returns ciphertext).
interface ascon_core_if #(
   parameter int DW = 128
);
   logic [DW-1:0] core_data;
   logic          core_valid;
   logic          core_last;
   logic          core_eot;
   logic          core_select;
   logic [4:0]    core_bytes;
   logic          core_read;
   logic          core_ct_valid;
   logic [DW-1:0] core_ct;
   logic          core_done;

   modport master (
      output core_data, core_valid, core_last,
      output core_eot, core_select, core_bytes,
      input  core_read, core_ct_valid, core_ct, core_done
   );

   modport slave (
      input  core_data, core_valid, core_last,
      input  core_eot, core_select, core_bytes,
      output core_read, core_ct_valid, core_ct, core_done
   );
endinterface

// File: rtl/ascon_block_sequencer.sv
// Streams host-preloaded AD/MSG blocks into the Ascon core and captures ciphertext.
// Ports: clk/rst_n; host wr_*/go/counts/rd_*; core bus (ascon_core_if.master); busy/done/error/ct_count.
module ascon_block_sequencer #(
   parameter int pDATA_WIDTH = 128,
   parameter int pAD_DEPTH   = 4,
   parameter int pMSG_DEPTH  = 4,
   parameter int pTIMEOUT    = 4096,
   localparam int MAXD = (pAD_DEPTH > pMSG_DEPTH) ? pAD_DEPTH : pMSG_DEPTH,
   localparam int AW   = (MAXD > 1) ? $clog2(MAXD) : 1,
   localparam int RW   = (pMSG_DEPTH > 1) ? $clog2(pMSG_DEPTH) : 1,
   localparam int ACW  = $clog2(pAD_DEPTH + 1),
   localparam int MCW  = $clog2(pMSG_DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic                   wr_sel,
   input  logic [AW-1:0]          wr_addr,
   input  logic [pDATA_WIDTH-1:0] wr_data,
   input  logic [ACW-1:0]         ad_blocks,
   input  logic [MCW-1:0]         msg_blocks,
   input  logic [4:0]             ad_last_bytes,
   input  logic [4:0]             msg_last_bytes,
   input  logic                   go,
   input  logic [RW-1:0]          rd_addr,
   output logic [pDATA_WIDTH-1:0] rd_data,
   ascon_core_if.master           core,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [MCW-1:0]         ct_count
);

   localparam int IW = (ACW > MCW) ? ACW : MCW;
   localparam int TW = $clog2(pTIMEOUT + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_AD,
      ST_SEND_MSG,
      ST_WAIT_DONE,
      ST_DONE,
      ST_ERROR
   } state_t;

   state_t state, state_nxt;

   logic [pDATA_WIDTH-1:0] ad_buf  [pAD_DEPTH];
   logic [pDATA_WIDTH-1:0] msg_buf [pMSG_DEPTH];
   logic [pDATA_WIDTH-1:0] ct_buf  [pMSG_DEPTH];

   logic [ACW-1:0] ad_n;
   logic [MCW-1:0] msg_n;
   logic [4:0]     ad_lb;
   logic [4:0]     msg_lb;
   logic [IW-1:0]  idx;
   logic [AW-1:0]  ia;
   logic [TW-1:0]  tmo_cnt;

   logic snd, start, rd_acc;
   logic ct_ok, ct_full, ct_wr, ct_ovf;
   logic tmo_hit, early_done, err;
   logic msg_empty, ad_last, msg_last, blk_last;

   assign ia         = idx[AW-1:0];
   assign snd        = (state == ST_SEND_AD) || (state == ST_SEND_MSG);
   assign busy       = snd || (state == ST_WAIT_DONE);
   assign done       = (state == ST_DONE);
   assign error      = (state == ST_ERROR);
   assign start      = go && !busy;
   assign rd_acc     = core.core_valid && core.core_read;
   assign ct_ok      = core.core_ct_valid &&
                       ((state == ST_SEND_MSG) || (state == ST_WAIT_DONE));
   assign ct_full    = (ct_count == MCW'(pMSG_DEPTH));
   assign ct_wr      = ct_ok && !ct_full;
   assign ct_ovf     = ct_ok && ct_full;
   assign tmo_hit    = (tmo_cnt == TW'(pTIMEOUT));
   assign early_done = core.core_done && snd;
   assign err        = tmo_hit || ct_ovf || early_done;

   // msg_blocks=0 still sends one padding-only block
   assign msg_empty  = (msg_n == '0);
   assign ad_last    = (idx == IW'(ad_n) - IW'(1));
   assign msg_last   = msg_empty || (idx == IW'(msg_n) - IW'(1));
   assign blk_last   = (state == ST_SEND_AD) ? ad_last : msg_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE, ST_DONE, ST_ERROR:
            if (go)
               state_nxt = (ad_blocks != '0) ? ST_SEND_AD : ST_SEND_MSG;
         ST_SEND_AD:
            if (err)                      state_nxt = ST_ERROR;
            else if (rd_acc && ad_last)   state_nxt = ST_SEND_MSG;
         ST_SEND_MSG:
            if (err)                      state_nxt = ST_ERROR;
            else if (rd_acc && msg_last)  state_nxt = ST_WAIT_DONE;
         ST_WAIT_DONE:
            if (err)                      state_nxt = ST_ERROR;
            else if (core.core_done)      state_nxt = ST_DONE;
         default:                         state_nxt = ST_IDLE;
      endcase
   end

   // Buffers carry no reset; writes are blocked for the whole run
   always_ff @(posedge clk) begin
      if (wr_en && !busy) begin
         if (!wr_sel && (int'(wr_addr) < pAD_DEPTH))
            ad_buf[wr_addr] <= wr_data;
         if (wr_sel && (int'(wr_addr) < pMSG_DEPTH))
            msg_buf[wr_addr] <= wr_data;
      end
      if (ct_wr)
         ct_buf[ct_count[RW-1:0]] <= core.core_ct;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if ((state_nxt != state) || rd_acc || core.core_ct_valid) begin
         tmo_cnt <= '0;
      end else if (busy) begin
         tmo_cnt <= tmo_cnt + TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data          <= '0;
         ad_n             <= '0;
         msg_n            <= '0;
         ad_lb            <= '0;
         msg_lb           <= '0;
         idx              <= '0;
         ct_count         <= '0;
         core.core_data   <= '0;
         core.core_valid  <= 1'b0;
         core.core_last   <= 1'b0;
         core.core_eot    <= 1'b0;
         core.core_select <= 1'b0;
         core.core_bytes  <= '0;
      end else begin
         rd_data <= ct_buf[rd_addr];
         if (start) begin
            ad_n     <= (ad_blocks > ACW'(pAD_DEPTH)) ? ACW'(pAD_DEPTH) : ad_blocks;
            msg_n    <= (msg_blocks > MCW'(pMSG_DEPTH)) ? MCW'(pMSG_DEPTH) : msg_blocks;
            ad_lb    <= ad_last_bytes;
            msg_lb   <= msg_last_bytes;
            idx      <= '0;
            ct_count <= '0;
            core.core_valid <= 1'b0;
         end else begin
            if (ct_wr)
               ct_count <= ct_count + MCW'(1);
            if (!snd || (state_nxt == ST_ERROR)) begin
               core.core_valid <= 1'b0;
            end else if (rd_acc) begin
               // drop valid for one cycle before the next block
               core.core_valid <= 1'b0;
               idx <= blk_last ? '0 : idx + IW'(1);
            end else if (!core.core_valid && (state_nxt == state)) begin
               core.core_valid  <= 1'b1;
               core.core_select <= (state == ST_SEND_MSG);
               core.core_last   <= blk_last;
               core.core_eot    <= (state == ST_SEND_MSG) && msg_last;
               if (state == ST_SEND_AD) begin
                  core.core_data  <= ad_buf[ia];
                  core.core_bytes <= ad_last ? ad_lb : 5'd16;
               end else begin
                  core.core_data  <= msg_empty ? '0 : msg_buf[ia];
                  core.core_bytes <= msg_empty ? 5'd0 :
                                     (msg_last ? msg_lb : 5'd16);
               end
            end
         end
      end
   end

endmodule
